// File: rtl/spi_lcd_pkg.sv
// Shared definitions for the SPI LCD init/write controller: ROM entry layout,
// opcodes and controller state encoding.
package spi_lcd_pkg;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e    op;
    logic [7:0] arg;
  } rom_entry_t;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    FETCH,
    ISSUE,
    WAIT_DONE,
    DELAY,
    READY,
    WR_WAIT
  } state_e;

  function automatic rom_entry_t make_entry(input opcode_e op, input logic [7:0] arg);
    rom_entry_t e;
    e.op  = op;
    e.arg = arg;
    return e;
  endfunction

endpackage

// File: rtl/spi_lcd_if.sv
// Handshake between the LCD controller (master) and an external SPI byte engine (slave).
interface spi_lcd_if;

  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_done;

  modport master (
    output spi_start,
    output spi_data,
    input  spi_done
  );

  modport slave (
    input  spi_start,
    input  spi_data,
    output spi_done
  );

endinterface

// File: rtl/lcd_init_rom.sv
// Panel initialisation table: combinational lookup from index to a 10-bit entry.
module lcd_init_rom
  import spi_lcd_pkg::*;
#(
  parameter int INIT_LEN = 32,
  parameter int IDX_W    = $clog2(INIT_LEN + 1)
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] entry
);

  // Anything past the table, or past INIT_LEN, reads back as END.
  always_comb begin
    entry = make_entry(OP_END, 8'h00);
    if (idx < IDX_W'(INIT_LEN)) begin
      case (idx)
        IDX_W'(0): entry = make_entry(OP_CMD,   8'h01);
        IDX_W'(1): entry = make_entry(OP_DELAY, 8'h02);
        IDX_W'(2): entry = make_entry(OP_CMD,   8'h3A);
        IDX_W'(3): entry = make_entry(OP_DATA,  8'h05);
        default:   entry = make_entry(OP_END,   8'h00);
      endcase
    end
  end

endmodule

// File: rtl/spi_lcd_ctrl.sv
// LCD panel controller: pulses the panel reset, plays the init ROM through an
// external SPI byte engine, then forwards user bytes one at a time.
module spi_lcd_ctrl
  import spi_lcd_pkg::*;
#(
  parameter int RST_HOLD   = 1000,
  parameter int DELAY_UNIT = 50000,
  parameter int INIT_LEN   = 32
) (
  input  logic        clk,
  input  logic        reset,
  spi_lcd_if.master   spi,
  output logic        lcd_dc,
  output logic        lcd_rst_n,
  input  logic        wr_valid,
  input  logic        wr_dc,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        init_done,
  output logic        busy
);

  localparam int CNT_MAX = (255 * DELAY_UNIT > RST_HOLD) ? 255 * DELAY_UNIT : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(INIT_LEN + 1);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   delay_last;
  logic [ENTRY_W-1:0] rom_word;
  rom_entry_t         entry;

  lcd_init_rom #(
    .INIT_LEN (INIT_LEN),
    .IDX_W    (IDX_W)
  ) u_rom (
    .idx   (idx),
    .entry (rom_word)
  );

  assign entry = rom_entry_t'(rom_word);

  // Single registered FSM; every output is a flop so the engine and panel see clean levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST_LOW;
      idx           <= '0;
      cnt           <= '0;
      delay_last    <= '0;
      lcd_rst_n     <= 1'b0;
      lcd_dc        <= 1'b0;
      spi.spi_start <= 1'b0;
      spi.spi_data  <= 8'h00;
      wr_ready      <= 1'b0;
      init_done     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (state)
        RST_LOW: begin
          if (cnt == CNT_W'(RST_HOLD - 1)) begin
            cnt       <= '0;
            lcd_rst_n <= 1'b1;
            state     <= RST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RST_WAIT: begin
          if (cnt == CNT_W'(RST_HOLD - 1)) begin
            cnt   <= '0;
            idx   <= '0;
            state <= FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        FETCH: begin
          if (idx == IDX_W'(INIT_LEN) || entry.op == OP_END) begin
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= READY;
          end else if (entry.op == OP_DELAY) begin
            // A zero-length delay just steps to the next entry without visiting DELAY.
            if (entry.arg == 8'h00) begin
              idx <= idx + IDX_W'(1);
            end else begin
              cnt        <= '0;
              delay_last <= CNT_W'(entry.arg) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
              state      <= DELAY;
            end
          end else begin
            spi.spi_data  <= entry.arg;
            lcd_dc        <= entry.op[0];
            spi.spi_start <= 1'b1;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          spi.spi_start <= 1'b0;
          state         <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (spi.spi_done) begin
            idx   <= idx + IDX_W'(1);
            state <= FETCH;
          end
        end

        DELAY: begin
          if (cnt == delay_last) begin
            cnt   <= '0;
            idx   <= idx + IDX_W'(1);
            state <= FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        READY: begin
          if (wr_valid && wr_ready) begin
            spi.spi_data  <= wr_data;
            lcd_dc        <= wr_dc;
            spi.spi_start <= 1'b1;
            wr_ready      <= 1'b0;
            busy          <= 1'b1;
            state         <= WR_WAIT;
          end
        end

        WR_WAIT: begin
          spi.spi_start <= 1'b0;
          if (spi.spi_done) begin
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= READY;
          end
        end

        default: begin
          state <= RST_LOW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_lcd_ctrl.sv
// Directed bench for spi_lcd_ctrl with a 20-cycle SPI engine model and a short init ROM.
module tb_spi_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_dc;
  logic       lcd_rst_n;
  logic       wr_valid;
  logic       wr_dc;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       init_done;
  logic       busy;

  logic       eng_done;
  logic       inject_done;
  int         eng_cnt;
  int         start_count = 0;
  int         compared    = 0;
  int         mismatched  = 0;

  spi_lcd_if spi_bus();

  spi_lcd_ctrl #(
    .RST_HOLD   (4),
    .DELAY_UNIT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi_bus.master),
    .lcd_dc    (lcd_dc),
    .lcd_rst_n (lcd_rst_n),
    .wr_valid  (wr_valid),
    .wr_dc     (wr_dc),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Engine model: done pulse is visible 20 cycles after the start pulse is visible.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (spi_bus.spi_start) begin
      eng_cnt  <= 19;
      eng_done <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt  <= eng_cnt - 1;
      eng_done <= (eng_cnt == 1);
    end else begin
      eng_done <= 1'b0;
    end
  end

  assign spi_bus.spi_done = eng_done | inject_done;

  always @(posedge clk) begin
    if (spi_bus.spi_start === 1'b1) start_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic dc, input logic [7:0] data);
    wr_valid = valid;
    wr_dc    = dc;
    wr_data  = data;
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return spi_bus.spi_start;
      1:       return spi_bus.spi_done;
      default: return init_done;
    endcase
  endfunction

  // Waits (on falling edges) until the chosen signal is high or the budget runs out.
  task automatic waitSignal(input int sel, input int max_cycles, output int cycles);
    cycles = 0;
    while (sigSel(sel) !== 1'b1 && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_lcd_rst_n"}, 32'(lcd_rst_n),         32'd0);
    checkOutput({tag, "_lcd_dc"},    32'(lcd_dc),            32'd0);
    checkOutput({tag, "_spi_start"}, 32'(spi_bus.spi_start), 32'd0);
    checkOutput({tag, "_spi_data"},  32'(spi_bus.spi_data),  32'h00);
    checkOutput({tag, "_wr_ready"},  32'(wr_ready),          32'd0);
    checkOutput({tag, "_init_done"}, 32'(init_done),         32'd0);
    checkOutput({tag, "_busy"},      32'(busy),              32'd1);
  endtask

  // Called on the falling edge where reset drops; returns on the edge the 0x3A start is visible.
  task automatic runInitPrefix();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      checkOutput("lcd_rst_n_low", 32'(lcd_rst_n), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("lcd_rst_n_high", 32'(lcd_rst_n), 32'd1);
      @(negedge clk);
    end
    waitSignal(0, 10, cyc);
    checkOutput("start_01_seen", 32'(spi_bus.spi_start), 32'd1);
    checkOutput("start_01_lat",  32'(cyc),                32'd1);
    checkOutput("data_01",       32'(spi_bus.spi_data),   32'h01);
    checkOutput("dc_01",         32'(lcd_dc),             32'd0);
    checkOutput("wr_ready_init", 32'(wr_ready),           32'd0);
    @(negedge clk);
    checkOutput("start_01_width", 32'(spi_bus.spi_start), 32'd0);
    waitSignal(1, 40, cyc);
    checkOutput("done_01_lat",  32'(cyc),               32'd19);
    checkOutput("data_01_hold", 32'(spi_bus.spi_data),  32'h01);
    checkOutput("busy_01",      32'(busy),              32'd1);
    waitSignal(0, 40, cyc);
    checkOutput("gap_after_01", 32'(cyc),               32'd19);
    checkOutput("data_3a",      32'(spi_bus.spi_data),  32'h3A);
    checkOutput("dc_3a",        32'(lcd_dc),            32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    reset       = 1'b1;
    inject_done = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h55);
    repeat (3) @(negedge clk);
    checkResetValues("rst0");
    reset = 1'b0;
    runInitPrefix();

    // Reset in the middle of the 0x3A transfer, then the whole sequence again.
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    runInitPrefix();

    waitSignal(1, 40, cyc);
    checkOutput("done_3a_lat",  32'(cyc),              32'd20);
    checkOutput("data_3a_hold", 32'(spi_bus.spi_data), 32'h3A);
    waitSignal(0, 10, cyc);
    checkOutput("gap_3a_05", 32'(cyc),              32'd2);
    checkOutput("data_05",   32'(spi_bus.spi_data), 32'h05);
    checkOutput("dc_05",     32'(lcd_dc),           32'd1);
    waitSignal(1, 40, cyc);
    checkOutput("done_05_lat", 32'(cyc), 32'd20);
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitSignal(2, 10, cyc);
    checkOutput("init_done_lat", 32'(cyc),       32'd2);
    checkOutput("init_done",     32'(init_done), 32'd1);
    checkOutput("ready_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("ready_busy",    32'(busy),      32'd0);
    checkOutput("starts_init",   32'(start_count), 32'd5);

    // A stray done pulse in READY must not disturb anything.
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stray_wr_ready", 32'(wr_ready),    32'd1);
    checkOutput("stray_busy",     32'(busy),        32'd0);
    checkOutput("stray_starts",   32'(start_count), 32'd5);

    applyStimulus(1'b1, 1'b1, 8'hA5);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("wr1_start",    32'(spi_bus.spi_start), 32'd1);
    checkOutput("wr1_data",     32'(spi_bus.spi_data),  32'hA5);
    checkOutput("wr1_dc",       32'(lcd_dc),            32'd1);
    checkOutput("wr1_wr_ready", 32'(wr_ready),          32'd0);
    checkOutput("wr1_busy",     32'(busy),              32'd1);
    @(negedge clk);
    checkOutput("wr1_width", 32'(spi_bus.spi_start), 32'd0);
    waitSignal(1, 40, cyc);
    checkOutput("wr1_done_lat",  32'(cyc),      32'd19);
    checkOutput("wr1_ready_low", 32'(wr_ready), 32'd0);
    @(negedge clk);
    checkOutput("wr1_ready_back", 32'(wr_ready), 32'd1);

    // Second write; a request raised during WR_WAIT must be ignored.
    applyStimulus(1'b1, 1'b0, 8'h3C);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("wr2_start", 32'(spi_bus.spi_start), 32'd1);
    checkOutput("wr2_data",  32'(spi_bus.spi_data),  32'h3C);
    checkOutput("wr2_dc",    32'(lcd_dc),            32'd0);
    @(negedge clk);
    waitSignal(1, 40, cyc);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("wr2_done_lat",  32'(cyc),              32'd19);
    checkOutput("wr2_data_hold", 32'(spi_bus.spi_data), 32'h3C);
    checkOutput("wr2_dc_hold",   32'(lcd_dc),           32'd0);
    @(negedge clk);
    checkOutput("wr2_ready_back", 32'(wr_ready), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("starts_total", 32'(start_count), 32'd7);

    reset = 1'b1;
    #1;
    checkOutput("final_init_done", 32'(init_done), 32'd0);
    checkOutput("final_wr_ready",  32'(wr_ready),  32'd0);
    checkOutput("final_busy",      32'(busy),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_lcd_ctrl.md
SPI_LCD_CTRL -- requirements
Module: spi_lcd_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 1000, meaning clk cycles lcd_rst_n is held low after reset.
REQ-002 SHALL have parameter DELAY_UNIT, default 50000, meaning clk cycles per delay tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter INIT_LEN, default 32, meaning number of init ROM entries.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port spi_start, output, 1, one-cycle start pulse to the SPI byte engine.
REQ-007 SHALL have port spi_data, output, 8, byte to transmit.
REQ-008 SHALL have port spi_done, input, 1, one-cycle completion pulse from the SPI byte engine.
REQ-009 SHALL have port lcd_dc, output, 1, panel data/command select (0=command, 1=data).
REQ-010 SHALL have port lcd_rst_n, output, 1, panel hardware reset, active low.
REQ-011 SHALL have port wr_valid, input, 1, user byte write request.
REQ-012 SHALL have port wr_dc, input, 1, dc value for the user byte.
REQ-013 SHALL have port wr_data, input, 8, user byte.
REQ-014 SHALL have port wr_ready, output, 1, accepts the user byte when high together with wr_valid.
REQ-015 SHALL have port init_done, output, 1, high once the init sequence completes; stays high until reset.
REQ-016 SHALL have port busy, output, 1, high whenever the block is not in READY.

Function
REQ-017 SHALL implement states RST_LOW, RST_WAIT, FETCH, ISSUE, WAIT_DONE, DELAY, READY, WR_WAIT.
REQ-018 RST_LOW SHALL drive lcd_rst_n=0 for RST_HOLD cycles, then go to RST_WAIT with lcd_rst_n=1.
REQ-019 RST_WAIT SHALL wait RST_HOLD cycles, then go to FETCH with ROM index 0.
REQ-020 ROM entries SHALL be 10 bits: [9:8] opcode (00 CMD, 01 DATA, 10 DELAY, 11 END), [7:0] argument.
REQ-021 FETCH with CMD/DATA SHALL set spi_data=argument and lcd_dc=opcode[0], then go to ISSUE.
REQ-022 ISSUE SHALL assert spi_start for exactly one cycle, then go to WAIT_DONE.
REQ-023 WAIT_DONE SHALL hold spi_data and lcd_dc stable until spi_done, then increment the index and return to FETCH.
REQ-024 FETCH with DELAY SHALL wait argument*DELAY_UNIT cycles in DELAY; argument 0 SHALL advance to FETCH on the next cycle.
REQ-025 FETCH with END, or an index equal to INIT_LEN, SHALL go to READY and set init_done=1.
REQ-026 READY SHALL assert wr_ready=1; on wr_valid&wr_ready it SHALL latch wr_data/wr_dc, pulse spi_start next cycle, enter WR_WAIT with wr_ready=0.
REQ-027 WR_WAIT SHALL return to READY on spi_done; minimum spacing of user bytes is start + engine time + 1 cycle.
REQ-028 wr_valid outside READY SHALL be ignored; wr_ready SHALL be 0 in all states other than READY.
REQ-029 spi_done outside WAIT_DONE/WR_WAIT SHALL be ignored.
REQ-030 Delay counters SHALL be wide enough for 255*DELAY_UNIT without wrap.

Reset
REQ-031 Reset SHALL force state RST_LOW, index 0, and counters 0; lcd_rst_n=0, lcd_dc=0, spi_start=0, spi_data=0, wr_ready=0, init_done=0, busy=1.
REQ-032 Reset mid-transfer SHALL abandon the byte and rerun the full init sequence from RST_LOW.

Structure
REQ-033 Opcode codes, state encodings and the ROM entry width SHALL live in shared package spi_lcd_pkg.
REQ-034 The init table SHALL be a separate combinational sub-module lcd_init_rom (index in, 10-bit entry out).
REQ-035 spi_lcd_ctrl SHALL NOT instantiate the SPI byte engine; the parent connects them.

Verification
REQ-036 Bench params: RST_HOLD=4, DELAY_UNIT=8; ROM = CMD 0x01, DELAY 2, CMD 0x3A, DATA 0x05, END; engine model returns spi_done 20 cycles after spi_start.
REQ-037 Reset released -> lcd_rst_n low 4 cycles, high 4 cycles, then spi_start with spi_data=0x01, lcd_dc=0.
REQ-038 After the 0x01 done -> no spi_start for 16 cycles, then 0x3A with dc=0 and 0x05 with dc=1, then init_done=1 and wr_ready=1.
REQ-039 In READY, wr_valid with wr_dc=1, wr_data=0xA5 -> one spi_start pulse with spi_data=0xA5, lcd_dc=1; wr_ready=0 until spi_done.
REQ-040 wr_valid held high during init and spi_done injected while in READY -> no extra spi_start and no state change.
REQ-041 Reset asserted during the 0x3A transfer -> all outputs at reset values immediately, then the sequence restarts from REQ-037.
